// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
// Holds the frame FSM states, data width and line levels.
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO feeding the UART transmit FSM.
// Pushes are refused while full and pops while empty, so callers may request freely.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  uart_byte_t               wr_data,
    input  logic                     pop,
    output uart_byte_t               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    uart_byte_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push_ok;
    logic                   pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// 8N1 UART transmitter: buffers producer bytes and serialises them LSB first onto txd.
// Frames run back to back while the FIFO has data; txd is a registered output.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                IDX_W     = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    uart_state_e        state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    uart_byte_t         shift_q, shift_d;
    logic               txd_q, txd_d;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    uart_byte_t         fifo_head;
    logic               bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end  = (baud_q == BAUD_LAST);
    assign tx_ready = !fifo_full;
    assign txd      = txd_q;
    assign busy     = (state_q != UART_IDLE) || !fifo_empty;

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        fifo_pop  = 1'b0;

        case (state_q)
            UART_IDLE: begin
                baud_d = '0;
                txd_d  = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    txd_d    = UART_START_LEVEL;
                    state_d  = UART_START;
                end
            end

            UART_START: begin
                if (bit_end) begin
                    txd_d     = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = UART_DATA;
                end
            end

            UART_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_LAST) begin
                        txd_d   = UART_STOP_LEVEL;
                        state_d = UART_STOP;
                    end else begin
                        // The line already carries shift_q[0]; the next bit is shift_q[1].
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end

            UART_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        txd_d    = UART_START_LEVEL;
                        state_d  = UART_START;
                    end else begin
                        txd_d   = UART_IDLE_LEVEL;
                        state_d = UART_IDLE;
                    end
                end
            end

            default: begin
                txd_d   = UART_IDLE_LEVEL;
                state_d = UART_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed and randomised checks of uart_tx_framer against a frame-level line model.
// Expected txd is derived from {stop, byte, start} held CPB cycles per bit.
module tb_uart_tx_framer;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [7:0]    exp_q [$];
    logic [7:0]    bytes [10];
    int            acc [10];

    uart_tx_framer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[k];
    endfunction

    // Call just after the edge on which the first start bit begins; returns just after
    // the edge that ends the last stop bit. Frames must be contiguous to pass.
    task automatic check_frames(input int n);
        for (int f = 0; f < n; f++) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            for (int k = 0; k < 10 * CPB; k++) begin
                @(negedge clk);
                check($sformatf("frame%0d_%02h_cyc%0d", f, b, k),
                      32'({txd, busy}), 32'({frame_bit(b, k / CPB), 1'b1}));
                @(posedge clk);
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check(tag, 32'({txd, tx_ready, busy, fifo_count}),
              32'({1'b1, 1'b1, 1'b0, CW'(0)}));
    endtask

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset and idle
        repeat (2) @(posedge clk);
        idle_check("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 50; i++) idle_check($sformatf("idle_cyc%0d", i));

        // Single 0xA5 frame; tx_data changes after acceptance must not matter
        @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = 8'hA5;
        @(posedge clk);
        #1 tx_valid = 1'b0; tx_data = 8'h5A;
        @(negedge clk);
        check("a5_line_before_pop", 32'({txd, busy, fifo_count}), 32'({1'b1, 1'b1, CW'(1)}));
        @(posedge clk);
        exp_q.push_back(8'hA5);
        check_frames(1);
        idle_check("a5_busy_falls");

        // 0x00 then 0xFF on consecutive edges: 80 contiguous cycles
        @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = 8'h00;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        check_frames(2);
        idle_check("b2b_idle_after");

        // Fill the FIFO with 10 distinct random bytes while tx_valid stays high
        for (int i = 0; i < 10; i++) begin
            logic dup;
            do begin
                bytes[i] = 8'($urandom_range(0, 255));
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (bytes[j] == bytes[i]) dup = 1'b1;
            end while (dup);
            exp_q.push_back(bytes[i]);
        end
        @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = bytes[0];
        fork
            begin : producer
                int wait_n;
                for (int i = 0; i < 10; i++) begin
                    tx_data = bytes[i];
                    @(negedge clk);
                    if (i == 9) begin
                        check("fill_full_flags", 32'({tx_ready, fifo_count}),
                              32'({1'b0, CW'(DEPTH)}));
                    end
                    wait_n = 0;
                    while (!tx_ready && wait_n < 500) begin
                        @(negedge clk);
                        wait_n++;
                    end
                    if (!tx_ready) begin
                        check("fill_ready_timeout", 32'(tx_ready), 32'd1);
                        break;
                    end
                    acc[i] = cyc;
                    @(posedge clk);
                    #1;
                end
                tx_valid = 1'b0;
            end
            begin : line_checker
                @(posedge clk);
                @(posedge clk);
                check_frames(10);
            end
        join
        for (int i = 1; i < 9; i++) begin
            check($sformatf("fill_accept_edge%0d", i), 32'(acc[i] - acc[0]), 32'(i));
        end
        check("fill_tenth_accept_edge", 32'(acc[9] - acc[0]), 32'd42);
        idle_check("fill_idle_after");

        // Reset on the 10th cycle of a frame with 3 bytes queued
        @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 tx_data = 8'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_queued", 32'({busy, fifo_count}), 32'({1'b1, CW'(3)}));
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle_check("rst_mid_after");
        @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = 8'h3C;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_line_before_pop", 32'(txd), 32'd1);
        @(posedge clk);
        exp_q.push_back(8'h3C);
        check_frames(1);
        idle_check("post_rst_idle");

        // Simultaneous push and pop with fifo_count == 3
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(bytes[i]);
        end
        @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = bytes[0];
        fork
            begin : pp_producer
                for (int i = 1; i < 4; i++) begin
                    @(posedge clk);
                    #1 tx_data = bytes[i];
                end
                @(posedge clk);
                #1 tx_valid = 1'b0;
                repeat (37) @(posedge clk);
                #1 tx_valid = 1'b1; tx_data = bytes[4];
                @(negedge clk);
                check("pushpop_before", 32'({tx_ready, fifo_count}), 32'({1'b1, CW'(3)}));
                @(posedge clk);
                #1 tx_valid = 1'b0;
                @(negedge clk);
                check("pushpop_after", 32'({tx_ready, fifo_count}), 32'({1'b1, CW'(3)}));
            end
            begin : pp_checker
                @(posedge clk);
                @(posedge clk);
                check_frames(5);
            end
        join
        idle_check("pushpop_idle_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
